// File: rtl/fetch_unit.sv
// Instruction/data fetch unit: PC and data address register, a two-state memory
// access FSM, and an optional access watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_pc,
  input  logic              load_pc,
  input  logic              addr_sel,
  input  logic              load_addr,
  input  logic [1:0]        mem_cmd,
  input  logic [DATA_W-1:0] datapath_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic              err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   pc_q,        pc_d;
  logic [ADDR_W-1:0]   dar_q,       dar_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q,    mem_we_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d;
  logic                rd_valid_q,  rd_valid_d;

  // Only 01 (read) and 10 (write) start an access; 00 and 11 are no-ops.
  logic cmd_valid;
  assign cmd_valid = mem_cmd[0] ^ mem_cmd[1];

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  // TIMEOUT only shapes the watchdog, which this build leaves out.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    dar_d       = dar_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    read_data_d = read_data_q;
    rd_valid_d  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif

    case (state_q)
      IDLE: begin
        // Launch address is taken from pre-edge pc/DAR, so a same-cycle load
        // of either register affects only the next access.
        if (cmd_valid) begin
          state_d     = ACCESS;
          mem_addr_d  = addr_sel ? pc_q : dar_q;
          mem_we_d    = mem_cmd[1];
          mem_wdata_d = datapath_out;
`ifdef FETCH_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
        if (load_pc) begin
          pc_d = reset_pc ? '0 : pc_q + ADDR_W'(1);
        end
        if (load_addr) begin
          dar_d = datapath_out[ADDR_W-1:0];
        end
      end

      ACCESS: begin
        if (mem_ready) begin
          state_d = IDLE;
          if (!mem_we_q) begin
            read_data_d = mem_rdata;
            rd_valid_d  = 1'b1;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      // NOTE: every register, including read_data, has a defined reset value;
      // nothing here is a memory array that could be left unreset.
      state_q     <= IDLE;
      pc_q        <= '0;
      dar_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dar_q       <= dar_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mem_req   = (state_q == ACCESS);
  assign busy      = (state_q == ACCESS);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign read_data = read_data_q;
  assign rd_valid  = rd_valid_q;
  assign pc        = pc_q;
`ifdef FETCH_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 9: memory address width.
REQ-002 Parameter DATA_W, default 16: memory and instruction word width.
REQ-003 Parameter TIMEOUT, default 15: maximum number of ACCESS cycles allowed (used only with FETCH_TIMEOUT_EN).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 reset_pc  in  1  when loading the PC, select 0 instead of PC+1.
REQ-007 load_pc  in  1  PC load enable.
REQ-008 addr_sel  in  1  access address source: 1 = PC, 0 = data address register (DAR).
REQ-009 load_addr  in  1  DAR load enable.
REQ-010 mem_cmd  in  2  command: 00 none, 01 MREAD, 10 MWRITE, 11 illegal.
REQ-011 datapath_out  in  DATA_W  DAR load source and write data source.
REQ-012 mem_req  out  1  memory request; held high through the whole access.
REQ-013 mem_we  out  1  1 = write access, 0 = read access.
REQ-014 mem_addr  out  ADDR_W  registered access address.
REQ-015 mem_wdata  out  DATA_W  registered write data.
REQ-016 mem_rdata  in  DATA_W  read data from memory; valid when mem_ready is high.
REQ-017 mem_ready  in  1  memory completion strobe.
REQ-018 read_data  out  DATA_W  last completed read word; feeds the CPU instruction register.
REQ-019 rd_valid  out  1  one-cycle pulse, high in the cycle after read_data is updated.
REQ-020 busy  out  1  high while an access is outstanding.
REQ-021 pc  out  ADDR_W  program counter.
REQ-022 err  out  1  sticky timeout flag.

Function
REQ-023 PC update: when load_pc=1 and busy=0, pc SHALL take 0 if reset_pc=1, else pc+1 modulo 2^ADDR_W (all-ones wraps to 0).
REQ-024 DAR update: when load_addr=1 and busy=0, DAR SHALL take datapath_out[ADDR_W-1:0].
REQ-025 The FSM SHALL have two states, IDLE and ACCESS.
REQ-026 Request launch: in IDLE, mem_cmd=01 or 10 SHALL move the FSM to ACCESS at the next edge and latch the following at that edge:
  - mem_addr from (addr_sel ? pc : DAR), using pre-edge values
  - mem_we = mem_cmd[1]
  - mem_wdata = datapath_out
REQ-027 In IDLE, mem_cmd=00 or 11 SHALL be ignored.
REQ-028 mem_req and busy SHALL both be 1 exactly while the FSM is in ACCESS.
REQ-029 In ACCESS with mem_ready=1, the FSM SHALL return to IDLE at the next edge; for a read, read_data SHALL capture mem_rdata at that same edge.
REQ-030 rd_valid SHALL pulse high for exactly one cycle after each completed read; it SHALL NOT pulse for writes.
REQ-031 Minimum latency: command sampled at edge k, mem_ready high in cycle k, read_data valid after edge k+1.
REQ-032 read_data SHALL hold its value until the next completed read.
REQ-033 mem_cmd, load_pc and load_addr SHALL be ignored while busy=1.
REQ-034 mem_ready SHALL be ignored in IDLE.
REQ-035 Simultaneous launch and load_pc in IDLE: the access SHALL use the old PC, and the PC SHALL update at the same edge.
REQ-036 Back-to-back operation: a new command may be accepted in the first IDLE cycle after completion.

Reset
REQ-037 With reset=0 at a rising edge, the block SHALL reset regardless of state; an in-flight access is aborted and mem_req is low after that edge.
REQ-038 Reset values: pc=0, DAR=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_req=0, busy=0, read_data=0, rd_valid=0, err=0, FSM=IDLE.

Configuration
REQ-039 Macro FETCH_TIMEOUT_EN defined: a counter SHALL count ACCESS cycles; after TIMEOUT cycles without mem_ready, the FSM returns to IDLE, err is set and stays set until reset, read_data is unchanged and rd_valid does not pulse.
REQ-040 Macro FETCH_TIMEOUT_EN undefined: ACCESS SHALL wait indefinitely for mem_ready, err SHALL be constant 0, and no counter logic SHALL be present.

Verification
REQ-041 Reset, then load_pc=1 with reset_pc=1 -> pc=0. Then 512 cycles of load_pc=1 -> pc wraps 511 -> 0.
REQ-042 pc=5, addr_sel=1, mem_cmd=01 and load_pc=1 together, memory returns 16'hD2A5 with mem_ready after 3 cycles -> mem_addr=5, pc=6, busy high 3 cycles, read_data=16'hD2A5, one rd_valid pulse.
REQ-043 load_addr with datapath_out=16'h0123, then mem_cmd=10 with addr_sel=0 and datapath_out=16'hBEEF -> mem_addr=9'h123, mem_we=1, mem_wdata=16'hBEEF, no rd_valid pulse.
REQ-044 mem_cmd=01 and load_pc pulsed while busy, plus mem_cmd=11 in IDLE -> no second request, pc unchanged.
REQ-045 reset=0 asserted in the second ACCESS cycle -> mem_req=0 after that edge, all outputs at reset values.
REQ-046 FETCH_TIMEOUT_EN defined, TIMEOUT=15, mem_ready never asserted -> FSM back to IDLE after 15 cycles, err=1 and held, read_data unchanged.
